// File: rtl/frodo_host_if.sv
// Frodo host interface: loads input words into RAM, starts the core, streams results out.
// Optional WAIT-state watchdog is built when FRODO_HOST_TIMEOUT_EN is defined.
module frodo_host_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic                  cfg_bank,
  input  logic [ADDR_WIDTH-1:0] cfg_wr_base,
  input  logic [ADDR_WIDTH-1:0] cfg_rd_base,
  input  logic [ADDR_WIDTH-1:0] cfg_rd_len,
  input  logic [1:0]            cfg_level,
  input  logic [1:0]            cfg_mode,
  input  logic                  s_valid,
  input  logic                  s_last,
  input  logic [63:0]           s_data,
  output logic                  s_ready,
  output logic                  ram_sel,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [63:0]           ram_wr_data,
  input  logic [63:0]           ram_rd_data,
  output logic                  core_start,
  output logic [1:0]            core_level,
  output logic [1:0]            core_mode,
  input  logic                  core_valid,
  output logic                  m_valid,
  output logic                  m_last,
  output logic [63:0]           m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_UNLOAD = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] L_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] L_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state, w_next;
  logic                  r_bank;
  logic [ADDR_WIDTH-1:0] r_wr_base, r_rd_base, r_rd_len;
  logic [1:0]            r_level, r_mode;
  logic [ADDR_WIDTH-1:0] r_wr_cnt, r_rd_cnt, r_addr;
  logic                  r_wr_en;
  logic [63:0]           r_wr_data;
  logic                  r_pend, r_pend_last;
  logic [1:0]            r_occ;
  logic [63:0]           r_buf0_data, r_buf1_data;
  logic                  r_buf0_last, r_buf1_last;

  logic                  w_go, w_hs, w_pop, w_rd_first, w_issue;
  logic [2:0]            w_fill;

  assign w_go       = (r_state == S_IDLE) & go;
  assign w_hs       = (r_state == S_LOAD) & s_valid;
  assign w_pop      = (r_occ != 2'd0) & m_ready;
  assign w_rd_first = (r_state == S_WAIT) & core_valid;
  // A word popped this cycle frees its slot, which keeps the stream at one word per cycle.
  assign w_fill     = {1'b0, r_occ} + {2'b00, r_pend} - {2'b00, w_pop};
  assign w_issue    = (r_state == S_UNLOAD) & (r_rd_cnt != r_rd_len) & (w_fill < 3'd2);

`ifdef FRODO_HOST_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        r_err;
  logic        w_expire;

  assign w_expire = (r_state == S_WAIT) & ~core_valid & (r_to_cnt == 32'(TIMEOUT - 1));

  // WAIT-state cycle counter and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == S_WAIT) r_to_cnt <= r_to_cnt + 32'd1;
      else                   r_to_cnt <= 32'd0;
      if (w_go)          r_err <= 1'b0;
      else if (w_expire) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^(32'(TIMEOUT));
  assign err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (go) w_next = S_LOAD;
        else    w_next = S_IDLE;
      end
      S_LOAD: begin
        if (w_hs & s_last) w_next = S_START;
        else               w_next = S_LOAD;
      end
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        if (core_valid) begin
          if (r_rd_len == L_ZERO) w_next = S_DONE;
          else                    w_next = S_UNLOAD;
        end
`ifdef FRODO_HOST_TIMEOUT_EN
        else if (w_expire) w_next = S_DONE;
`endif
        else w_next = S_WAIT;
      end
      S_UNLOAD: begin
        if (w_pop & r_buf0_last) w_next = S_DONE;
        else                     w_next = S_UNLOAD;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Job configuration, counters and the registered RAM port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank      <= 1'b0;
      r_wr_base   <= L_ZERO;
      r_rd_base   <= L_ZERO;
      r_rd_len    <= L_ZERO;
      r_level     <= 2'd0;
      r_mode      <= 2'd0;
      r_wr_cnt    <= L_ZERO;
      r_rd_cnt    <= L_ZERO;
      r_addr      <= L_ZERO;
      r_wr_en     <= 1'b0;
      r_wr_data   <= 64'd0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
    end else begin
      if (w_go) begin
        r_bank    <= cfg_bank;
        r_wr_base <= cfg_wr_base;
        r_rd_base <= cfg_rd_base;
        r_rd_len  <= cfg_rd_len;
        r_level   <= cfg_level;
        r_mode    <= cfg_mode;
        r_wr_cnt  <= L_ZERO;
        r_rd_cnt  <= L_ZERO;
      end
      r_wr_en <= w_hs;
      if (w_hs) begin
        r_wr_data <= s_data;
        r_wr_cnt  <= r_wr_cnt + L_ONE;
      end
      // In UNLOAD r_addr always shows the next unissued read address.
      if (w_hs)            r_addr <= r_wr_base + r_wr_cnt;
      else if (w_rd_first) r_addr <= r_rd_base;
      else if (w_issue)    r_addr <= r_addr + L_ONE;
      if (w_issue) r_rd_cnt <= r_rd_cnt + L_ONE;
      r_pend      <= w_issue;
      r_pend_last <= w_issue & (r_rd_cnt == r_rd_len - L_ONE);
    end
  end

  // Two-entry result buffer, head in slot 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ       <= 2'd0;
      r_buf0_data <= 64'd0;
      r_buf1_data <= 64'd0;
      r_buf0_last <= 1'b0;
      r_buf1_last <= 1'b0;
    end else begin
      case ({r_pend, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_buf0_data <= ram_rd_data;
            r_buf0_last <= r_pend_last;
          end else begin
            r_buf1_data <= ram_rd_data;
            r_buf1_last <= r_pend_last;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0_data <= r_buf1_data;
          r_buf0_last <= r_buf1_last;
          r_occ       <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_buf0_data <= ram_rd_data;
            r_buf0_last <= r_pend_last;
          end else begin
            r_buf0_data <= r_buf1_data;
            r_buf0_last <= r_buf1_last;
            r_buf1_data <= ram_rd_data;
            r_buf1_last <= r_pend_last;
          end
        end
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign s_ready     = (r_state == S_LOAD);
  assign ram_sel     = r_bank;
  assign ram_wr_en   = r_wr_en;
  assign ram_addr    = r_addr;
  assign ram_wr_data = r_wr_data;
  assign core_start  = (r_state == S_START);
  assign core_level  = r_level;
  assign core_mode   = r_mode;
  assign m_valid     = (r_occ != 2'd0);
  assign m_last      = (r_occ != 2'd0) & r_buf0_last;
  assign m_data      = r_buf0_data;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);

endmodule
